sub_rr_sched: RTL

Round-robin scheduler that shares one bit-serial subtract engine between two requesters. The engine is a single existing full_sub cell plus a borrow flop. The block grants one requester, latches its operands, and sequences a-b LSB-first over WIDTH cycles. It then presents {borrow,diff} with a one-cycle done strobe tagged with the requester id. It sits between client logic and the subtractor cell, replacing a WIDTH-wide ripple array with one shared cell.

---
 rtl/sub_pkg.sv | 22 ++
 rtl/full_sub.sv | 13 +
 rtl/sub_rr_sched.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared types and helpers for the round-robin bit-serial subtract scheduler.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int WIDTH_DEF = 10;
  localparam int CNT_W     = $clog2(WIDTH_DEF);

  // Two-way round-robin pick: on a tie the requester that did not win last time goes.
  function automatic logic [1:0] rr_pick(input logic r0, input logic r1, input logic last);
    logic [1:0] g;
    g = 2'b00;
    if (r0 && r1) g = last ? 2'b01 : 2'b10;
    else          g = {r1, r0};
    return g;
  endfunction

endpackage

// File: rtl/full_sub.sv
// Single-bit full subtractor: a - b - bin -> d with borrow-out.
module full_sub (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/sub_rr_sched.sv
// Round-robin scheduler sharing one bit-serial subtractor between two requesters.
//
//   state | meaning
//   IDLE  | arbitrate; grant latches operands of the winner
//   SHIFT | WIDTH cycles of LSB-first subtraction through the shared cell
//   DONE  | one-cycle result strobe; result registers hold afterwards
module sub_rr_sched
  import sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CntW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bflop_q, bflop_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Holds the WIDTH-1 result bits already produced; the final bit joins them on the last shift.
  logic [WIDTH-2:0] diff_sh_q, diff_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             done_id_q, done_id_d;

  logic             y_bit;
  logic             bout;
  logic [WIDTH-1:0] diff_full;

  full_sub u_full_sub (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .bin_i  (bflop_q),
    .d_o    (y_bit),
    .bout_o (bout)
  );

  assign diff_full = {y_bit, diff_sh_q};

  // Next-state, arbitration and serial datapath sequencing.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    bflop_d   = bflop_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    diff_sh_d = diff_sh_q;
    diff_d    = diff_q;
    borrow_d  = borrow_q;
    done_id_d = done_id_q;
    gnt       = 2'b00;

    case (state_q)
      IDLE: begin
        gnt = rr_pick(req0, req1, last_q);
        if (gnt != 2'b00) begin
          id_d    = gnt[1];
          last_d  = gnt[1];
          a_sh_d  = gnt[1] ? a1 : a0;
          b_sh_d  = gnt[1] ? b1 : b0;
          bflop_d = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        diff_sh_d = (WIDTH-1)'(diff_full >> 1);
        bflop_d   = bout;
        cnt_d     = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          diff_d    = diff_full;
          borrow_d  = bout;
          done_id_d = id_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      cnt_q     <= '0;
      bflop_q   <= 1'b0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      diff_q    <= '0;
      borrow_q  <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      bflop_q   <= bflop_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      diff_sh_q <= diff_sh_d;
      diff_q    <= diff_d;
      borrow_q  <= borrow_d;
      done_id_q <= done_id_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign done_id = done_id_q;
  assign diff    = diff_q;
  assign borrow  = borrow_q;

endmodule
